// File: rtl/cc_lookup_dispatch.sv
// Lookup-result dispatcher: pushes hit flags/data to the reorder FIFOs and issues AXI WRAP reads on misses.
// Optional perf counters enabled by defining CC_LOOKUP_DISPATCH_PERF_EN.
module cc_lookup_dispatch #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic                  lookup_hit_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic [511:0]          lookup_data_i,
  input  logic                  hit_flag_fifo_afull_i,
  output logic                  hit_flag_fifo_wren_o,
  output logic                  hit_flag_fifo_wdata_o,
  input  logic                  hit_data_fifo_afull_i,
  output logic                  hit_data_fifo_wren_o,
  output logic [517:0]          hit_data_fifo_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rlast_done_i,
`ifdef CC_LOOKUP_DISPATCH_PERF_EN
  input  logic                  perf_clr_i,
  output logic [31:0]           perf_hit_cnt_o,
  output logic [31:0]           perf_miss_cnt_o,
`endif
  output logic [2:0]            outstanding_o
);

  typedef enum logic [0:0] {IDLE, AR_WAIT} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  state_t state;
  logic   accept;
  logic   accept_hit;
  logic   accept_miss;
  logic   ar_hs;
  logic   rlast_dec;

  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'b011;
  assign mem_arburst_o = 2'b10;

  assign lookup_ready_o = (state == IDLE) && !hit_flag_fifo_afull_i &&
                          (lookup_hit_i ? !hit_data_fifo_afull_i : (outstanding_o < MAX_CNT));

  assign accept      = lookup_valid_i && lookup_ready_o;
  assign accept_hit  = accept && lookup_hit_i;
  assign accept_miss = accept && !lookup_hit_i;
  assign ar_hs       = mem_arvalid_o && mem_arready_i;
  // A completion with nothing outstanding is a stray pulse; drop it rather than wrap.
  assign rlast_dec   = mem_rlast_done_i && (outstanding_o != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      hit_flag_fifo_wren_o  <= 1'b0;
      hit_flag_fifo_wdata_o <= 1'b0;
      hit_data_fifo_wren_o  <= 1'b0;
      hit_data_fifo_wdata_o <= '0;
      mem_arvalid_o         <= 1'b0;
      mem_araddr_o          <= '0;
      outstanding_o         <= '0;
    end else begin
      hit_flag_fifo_wren_o <= accept;
      hit_data_fifo_wren_o <= accept_hit;
      if (accept) begin
        hit_flag_fifo_wdata_o <= lookup_hit_i;
      end
      if (accept_hit) begin
        hit_data_fifo_wdata_o <= {lookup_addr_i[5:0], lookup_data_i};
      end

      case (state)
        IDLE: begin
          if (accept_miss) begin
            mem_arvalid_o <= 1'b1;
            mem_araddr_o  <= {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
            state         <= AR_WAIT;
          end
        end
        AR_WAIT: begin
          if (mem_arready_i) begin
            mem_arvalid_o <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      case ({ar_hs, rlast_dec})
        2'b10:   outstanding_o <= outstanding_o + 3'd1;
        2'b01:   outstanding_o <= outstanding_o - 3'd1;
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

`ifdef CC_LOOKUP_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_cnt_o  <= '0;
      perf_miss_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_hit_cnt_o  <= '0;
      perf_miss_cnt_o <= '0;
    end else begin
      if (accept_hit)  perf_hit_cnt_o  <= perf_hit_cnt_o + 32'd1;
      if (accept_miss) perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cc_lookup_dispatch.sv
// Directed bench for cc_lookup_dispatch with a transaction-level reference model and per-cycle compare.
module tb_cc_lookup_dispatch;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, ready, hit;
  logic [31:0]  addr;
  logic [511:0] data;
  logic         flag_afull, flag_wren, flag_wdata;
  logic         data_afull, data_wren;
  logic [517:0] data_wdata;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready, rlast;
  logic [2:0]   outstanding;
`ifdef CC_LOOKUP_DISPATCH_PERF_EN
  logic         perf_clr;
  logic [31:0]  perf_hit, perf_miss;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  cc_lookup_dispatch #(.MAX_OUTSTANDING(4), .ADDR_WIDTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .lookup_valid_i        (valid),
    .lookup_ready_o        (ready),
    .lookup_hit_i          (hit),
    .lookup_addr_i         (addr),
    .lookup_data_i         (data),
    .hit_flag_fifo_afull_i (flag_afull),
    .hit_flag_fifo_wren_o  (flag_wren),
    .hit_flag_fifo_wdata_o (flag_wdata),
    .hit_data_fifo_afull_i (data_afull),
    .hit_data_fifo_wren_o  (data_wren),
    .hit_data_fifo_wdata_o (data_wdata),
    .mem_araddr_o          (araddr),
    .mem_arlen_o           (arlen),
    .mem_arsize_o          (arsize),
    .mem_arburst_o         (arburst),
    .mem_arvalid_o         (arvalid),
    .mem_arready_i         (arready),
    .mem_rlast_done_i      (rlast),
`ifdef CC_LOOKUP_DISPATCH_PERF_EN
    .perf_clr_i            (perf_clr),
    .perf_hit_cnt_o        (perf_hit),
    .perf_miss_cnt_o       (perf_miss),
`endif
    .outstanding_o         (outstanding)
  );

  task automatic chk(input string name, input logic [517:0] act, input logic [517:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a pending-AR flag, a miss count, and the pushes each accepted request must cause.
  logic         m_pending;
  int           m_cnt;
  logic         m_ready;
  logic         m_fw, m_fd, m_dw;
  logic [517:0] m_dd;
  logic [31:0]  m_aa;

  always_comb m_ready = !m_pending && !flag_afull && (hit ? !data_afull : (m_cnt < 4));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0; m_cnt <= 0; m_fw <= 1'b0; m_fd <= 1'b0;
      m_dw <= 1'b0; m_dd <= '0; m_aa <= '0;
    end else begin
      automatic bit acc = valid && m_ready;
      automatic int nc  = m_cnt;
      if (m_pending && arready) nc = nc + 1;
      if (rlast && m_cnt > 0)   nc = nc - 1;
      m_cnt <= nc;
      m_fw  <= acc;
      m_dw  <= acc && hit;
      if (acc) m_fd <= hit;
      if (acc && hit) m_dd <= {addr[5:0], data};
      if (m_pending && arready) m_pending <= 1'b0;
      if (acc && !hit) begin
        m_pending <= 1'b1;
        m_aa      <= addr & ~32'h7;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("ready", ready, m_ready);
      chk("flag_wren", flag_wren, m_fw);
      if (m_fw) chk("flag_wdata", flag_wdata, m_fd);
      chk("data_wren", data_wren, m_dw);
      if (m_dw) chk("data_wdata", data_wdata, m_dd);
      chk("arvalid", arvalid, m_pending);
      if (m_pending) chk("araddr", araddr, m_aa);
      chk("outstanding", outstanding, 518'(m_cnt));
      chk("ar_const", {arlen, arsize, arburst}, {4'd7, 3'b011, 2'b10});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Miss accepted with arready already high: AR handshakes on its first cycle.
  task automatic quick_miss(input logic [31:0] a);
    valid = 1'b1; hit = 1'b0; addr = a; arready = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    arready = 1'b0;
  endtask

  task automatic pulse_rlast();
    rlast = 1'b1;
    tick();
    rlast = 1'b0;
  endtask

  logic [511:0] pat_a;
  int           av_cycles;

  initial begin
    pat_a = {8{64'h0123_4567_89AB_CDEF}};
    rst = 1'b1; valid = 1'b0; hit = 1'b0; addr = '0; data = '0;
    flag_afull = 1'b0; data_afull = 1'b0; arready = 1'b0; rlast = 1'b0;
`ifdef CC_LOOKUP_DISPATCH_PERF_EN
    perf_clr = 1'b0;
`endif
    #12;
    chk("rst_outputs", {flag_wren, flag_wdata, data_wren, arvalid, outstanding, araddr},
        {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0});
    chk("rst_data", data_wdata, '0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single hit
    valid = 1'b1; hit = 1'b1; addr = 32'h0000_1028; data = pat_a;
    at_neg();
    chk("hit_ready", ready, 1'b1);
    tick();
    valid = 1'b0;
    at_neg();
    chk("hit_push", {flag_wren, flag_wdata, data_wren, arvalid}, 4'b1110);
    chk("hit_wdata", data_wdata, {6'h28, pat_a});
    tick();

    // Miss with arready low for three arvalid cycles
    valid = 1'b1; hit = 1'b0; addr = 32'h0000_2044; arready = 1'b0;
    tick();
    valid = 1'b0;
    av_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) arready = 1'b1;
      at_neg();
      if (arvalid) av_cycles++;
      chk("miss_araddr", araddr, 32'h0000_2040);
      chk("miss_ready_low", ready, 1'b0);
      tick();
    end
    arready = 1'b0;
    at_neg();
    chk("miss_av_cycles", av_cycles, 4);
    chk("miss_done", {arvalid, outstanding}, {1'b0, 3'd1});
    tick();
    pulse_rlast();

    // Fill to MAX_OUTSTANDING, stall a miss, still accept a hit
    for (int i = 0; i < 4; i++) quick_miss(32'h0000_4000 + 32'(i) * 32'h40);
    at_neg();
    chk("full_cnt", outstanding, 3'd4);
    valid = 1'b1; hit = 1'b0; addr = 32'h0000_5008;
    at_neg();
    chk("full_miss_stall", ready, 1'b0);
    tick();
    hit = 1'b1; addr = 32'h0000_5010; data = ~pat_a;
    at_neg();
    chk("full_hit_ok", ready, 1'b1);
    tick();
    hit = 1'b0; addr = 32'h0000_5008;
    rlast = 1'b1;
    tick();
    rlast = 1'b0; arready = 1'b1;
    at_neg();
    chk("after_rlast_ready", ready, 1'b1);
    tick();
    valid = 1'b0;
    tick();
    arready = 1'b0;
    at_neg();
    chk("refill_cnt", outstanding, 3'd4);
    for (int i = 0; i < 4; i++) pulse_rlast();

    // Flag FIFO almost full blocks a hit
    flag_afull = 1'b1; valid = 1'b1; hit = 1'b1; addr = 32'h0000_0100;
    at_neg();
    chk("afull_ready", ready, 1'b0);
    tick();
    at_neg();
    chk("afull_no_push", flag_wren, 1'b0);
    flag_afull = 1'b0;
    tick();
    valid = 1'b0;
    at_neg();
    chk("afull_release_push", {flag_wren, data_wren}, 2'b11);
    tick();

    // Simultaneous AR handshake and rlast at outstanding=2
    quick_miss(32'h0000_6000);
    quick_miss(32'h0000_6040);
    valid = 1'b1; hit = 1'b0; addr = 32'h0000_6080;
    tick();
    valid = 1'b0; arready = 1'b1; rlast = 1'b1;
    tick();
    arready = 1'b0; rlast = 1'b0;
    at_neg();
    chk("simul_cnt", outstanding, 3'd2);
    pulse_rlast();
    pulse_rlast();
    pulse_rlast();
    at_neg();
    chk("no_underflow", outstanding, 3'd0);

    // Reset during AR_WAIT
    valid = 1'b1; hit = 1'b0; addr = 32'h0000_7000;
    tick();
    valid = 1'b0;
    chk("pre_rst_push", {flag_wren, arvalid}, 2'b11);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_drop", {flag_wren, data_wren, arvalid}, 3'b000);
    tick();
    rst = 1'b0;
    valid = 1'b1; hit = 1'b1; addr = 32'h0000_7100;
    at_neg();
    chk("post_rst", {ready, arvalid, outstanding}, {1'b1, 1'b0, 3'd0});
    tick();
    valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_lookup_dispatch.md
Name: cc_lookup_dispatch

Overview:
- Stage directly upstream of the data reorder unit in the cache controller.
- Takes one tag-lookup result per request and, for each, pushes a hit flag into the hit-flag FIFO.
- Hit: pushes the line plus critical-word offset into the hit-data FIFO.
- Miss: issues an AXI wrap-burst read on the AR channel to memory.
- Request order is preserved through the flag FIFO; outstanding misses are tracked so the reorder unit's R path never overflows.

Parameters:
- MAX_OUTSTANDING, 4: maximum AR bursts issued whose last R beat has not yet been consumed.
- ADDR_WIDTH, 32: request/AR address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- lookup_valid_i  in  1  lookup result valid.
- lookup_ready_o  out  1  lookup result accepted when valid && ready.
- lookup_hit_i  in  1  1 = hit, 0 = miss.
- lookup_addr_i  in  ADDR_WIDTH  requested byte address.
- lookup_data_i  in  512  cache line (valid on hit).
- hit_flag_fifo_afull_i  in  1  flag FIFO almost full.
- hit_flag_fifo_wren_o  out  1  flag FIFO push.
- hit_flag_fifo_wdata_o  out  1  pushed flag.
- hit_data_fifo_afull_i  in  1  data FIFO almost full.
- hit_data_fifo_wren_o  out  1  data FIFO push.
- hit_data_fifo_wdata_o  out  518  {addr[5:0], line[511:0]}.
- mem_araddr_o  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:3], 3'b000}.
- mem_arlen_o  out  4  constant 4'd7.
- mem_arsize_o  out  3  constant 3'b011.
- mem_arburst_o  out  2  constant 2'b10 (WRAP).
- mem_arvalid_o  out  1  AR valid.
- mem_arready_i  in  1  AR ready.
- mem_rlast_done_i  in  1  pulse: an R beat with rvalid && rready && rlast completed.
- outstanding_o  out  3  current outstanding-miss count.

Behaviour:
- Reset values: every output 0 (constant AR fields excepted), FSM in IDLE, outstanding = 0.
- FSM states:
  - IDLE: accept lookups.
  - AR_WAIT: hold AR until handshake.
- lookup_ready_o = (state==IDLE) && !hit_flag_fifo_afull_i && (lookup_hit_i ? !hit_data_fifo_afull_i : outstanding < MAX_OUTSTANDING). Combinational; does not depend on lookup_valid_i.
- Accepted hit:
  - Next cycle: hit_flag_fifo_wren_o=1 with wdata=1, and hit_data_fifo_wren_o=1 with registered {addr[5:0], data}.
  - Both pulses last exactly one cycle; state stays IDLE. Back-to-back hits are possible every cycle.
- Accepted miss:
  - Next cycle: hit_flag_fifo_wren_o=1 with wdata=0, mem_arvalid_o=1, mem_araddr_o registered; state goes to AR_WAIT.
- AR_WAIT:
  - arvalid and araddr are held stable until mem_arready_i.
  - On handshake: arvalid deasserts next cycle, state returns to IDLE, outstanding increments.
  - lookup_ready_o=0 throughout.
- AR handshake on the first arvalid cycle is legal: AR_WAIT lasts one cycle.
- outstanding:
  - +1 on AR handshake; -1 on mem_rlast_done_i.
  - Both in the same cycle: unchanged.
  - mem_rlast_done_i while outstanding==0 is ignored (no underflow).
  - Never exceeds MAX_OUTSTANDING, because ready gating guarantees it.
- Flag push always occurs in the cycle after acceptance, so flag order equals request order. Hit-data and AR pushes never reorder relative to flags.
- FIFO full overflow is impossible: the afull thresholds leave at least one slot of margin for the single in-flight registered push.
- Reset asserted mid-operation: all pushes and arvalid drop immediately (async); a pending AR is abandoned; the counter clears.

Optional Feature:
- Macro CC_LOOKUP_DISPATCH_PERF_EN.
- Defined:
  - Adds output ports perf_hit_cnt_o [31:0] and perf_miss_cnt_o [31:0], each incremented on the accept cycle of a hit/miss respectively.
  - Counters wrap at 2^32, reset to 0, and are cleared by a one-cycle input perf_clr_i. Clear wins over increment in the same cycle.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Hit, addr=0x0000_1028, data=pattern A, FIFOs empty -> cycle+1: flag wren with wdata=1; data wren with wdata={6'h28, A}; no arvalid.
- Miss, addr=0x0000_2044, mem_arready_i held 0 for 3 cycles then 1:
  - arvalid high 4 cycles with araddr=0x0000_2040, arlen=7, arburst=2'b10.
  - One flag push with wdata=0; lookup_ready_o low until return to IDLE; outstanding goes 0->1.
- 4 misses with arready=1 and no rlast_done -> outstanding=4; a 5th miss is stalled (ready=0) while a hit is still accepted. One rlast_done pulse -> 5th miss accepted.
- hit_flag_fifo_afull_i=1 with a valid hit -> ready=0, no pushes. afull drops -> accept, pushes next cycle.
- AR handshake and rlast_done in the same cycle with outstanding=2 -> outstanding stays 2. rlast_done with outstanding=0 -> stays 0.
- Assert rst during AR_WAIT -> arvalid and wren outputs go 0 asynchronously; after release, state is IDLE, outstanding=0, and ready is high with FIFOs not afull.
